// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle for sram_bus_arbiter: two requester ports (ibus, dbus) and the shared SRAM port.
// slave = arbiter side, master = requester/memory side.
interface sram_bus_arbiter_if;
    logic [31:0] ibus_address;
    logic [3:0]  ibus_byteenable;
    logic        ibus_read;
    logic        ibus_write;
    logic [31:0] ibus_wrdata;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;

    logic [31:0] dbus_address;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_wrdata;
    logic [31:0] dbus_rddata;
    logic        dbus_stall;

    logic [29:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;

    modport slave (
        input  ibus_address, ibus_byteenable, ibus_read, ibus_write, ibus_wrdata,
        output ibus_rddata, ibus_stall,
        input  dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
        output dbus_rddata, dbus_stall,
        output mem_address, mem_byteenable, mem_rd, mem_wr, mem_wrdata,
        input  mem_rddata
    );

    modport master (
        output ibus_address, ibus_byteenable, ibus_read, ibus_write, ibus_wrdata,
        input  ibus_rddata, ibus_stall,
        output dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
        input  dbus_rddata, dbus_stall,
        input  mem_address, mem_byteenable, mem_rd, mem_wr, mem_wrdata,
        output mem_rddata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-port (ibus/dbus) arbiter onto a single fixed-latency SRAM port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed dbus priority.
//
// Handshake: a port requests by holding read or write high; stall is high while the request
// is pending and drops for exactly one cycle (DONE) when that port's transaction completes.
module sram_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_bus_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state,
    output logic                 dbg_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        grant;        // 1 = dbus, 0 = ibus
    logic        is_write;
    logic [3:0]  cnt;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic [31:0] ibus_rd_q;
    logic [31:0] dbus_rd_q;

    logic        ibus_pend;
    logic        dbus_pend;
    logic        pick_dbus;
    logic        last_cycle;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{bus.ibus_address[1:0], bus.dbus_address[1:0]};

    assign ibus_pend  = bus.ibus_read | bus.ibus_write;
    assign dbus_pend  = bus.dbus_read | bus.dbus_write;
    assign last_cycle = (cnt <= 4'd1);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    // last_grant resets to ibus so that dbus wins the first contention.
    assign pick_dbus = dbus_pend & (~ibus_pend | ~last_grant);
`else
    assign pick_dbus = dbus_pend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ibus_pend | dbus_pend) state_next = ACCESS;
            ACCESS:  if (last_cycle)            state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= 1'b0;
            is_write  <= 1'b0;
            cnt       <= 4'd0;
            addr_q    <= 30'd0;
            be_q      <= 4'd0;
            wd_q      <= 32'd0;
            ibus_rd_q <= 32'd0;
            dbus_rd_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ibus_pend | dbus_pend) begin
                        grant    <= pick_dbus;
                        cnt      <= 4'(WAIT_CYCLES);
                        // Write dominates when both strobes are high.
                        is_write <= pick_dbus ? bus.dbus_write : bus.ibus_write;
                        addr_q   <= pick_dbus ? bus.dbus_address[31:2] : bus.ibus_address[31:2];
                        be_q     <= pick_dbus ? bus.dbus_byteenable : bus.ibus_byteenable;
                        wd_q     <= pick_dbus ? bus.dbus_wrdata : bus.ibus_wrdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= pick_dbus;
`endif
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (last_cycle && !is_write) begin
                        if (grant) begin
                            dbus_rd_q <= bus.mem_rddata;
                        end else begin
                            ibus_rd_q <= bus.mem_rddata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from the state register so reset removes them immediately.
    assign bus.mem_rd         = (state == ACCESS) & ~is_write;
    assign bus.mem_wr         = (state == ACCESS) &  is_write;
    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_wrdata     = wd_q;

    assign bus.ibus_rddata = ibus_rd_q;
    assign bus.dbus_rddata = dbus_rd_q;
    assign bus.ibus_stall  = ibus_pend & ~((state == DONE) & ~grant);
    assign bus.dbus_stall  = dbus_pend & ~((state == DONE) &  grant);

    assign dbg_state = state;
    assign dbg_grant = grant;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: vector table for single transactions plus
// hand sequences for withdrawal, reset abort and two-port contention.
module tb_sram_bus_arbiter;
  localparam int W = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  logic dbg_grant;
  int checks;
  int failures;

  sram_bus_arbiter_if bus();

  sram_bus_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state(dbg_state),
    .dbg_grant(dbg_grant)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic i_rd;
    logic i_wr;
    logic [31:0] i_addr;
    logic [3:0] i_be;
    logic [31:0] i_wd;
    logic d_rd;
    logic d_wr;
    logic [31:0] d_addr;
    logic [3:0] d_be;
    logic [31:0] d_wd;
    logic [31:0] mem_rdata;
    logic exp_gnt_d;
    logic [29:0] exp_addr;
    logic [3:0] exp_be;
    logic [31:0] exp_wd;
    logic exp_write;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.ibus_read = 1'b0; bus.ibus_write = 1'b0;
    bus.dbus_read = 1'b0; bus.dbus_write = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.ibus_read = v.i_rd; bus.ibus_write = v.i_wr; bus.ibus_address = v.i_addr;
    bus.ibus_byteenable = v.i_be; bus.ibus_wrdata = v.i_wd;
    bus.dbus_read = v.d_rd; bus.dbus_write = v.d_wr; bus.dbus_address = v.d_addr;
    bus.dbus_byteenable = v.d_be; bus.dbus_wrdata = v.d_wd;
    bus.mem_rddata = v.mem_rdata;
  endtask

  // Applies one transaction at a negedge in IDLE (cycle 0) and checks it through DONE.
  task automatic run_vec(input int idx, input vec_t v);
    int done_k;
    int rd_n;
    int wr_n;
    logic stable;
    logic gstall;
    string tag;
    done_k = 0; rd_n = 0; wr_n = 0; stable = 1'b1;
    tag = $sformatf("v%0d", idx);
    drive_vec(v);
    for (int k = 1; k <= 12 && done_k == 0; k++) begin
      @(negedge clk);
      rd_n += int'(bus.mem_rd);
      wr_n += int'(bus.mem_wr);
      if (dbg_state == S_ACCESS &&
          (bus.mem_address !== v.exp_addr || bus.mem_byteenable !== v.exp_be ||
           bus.mem_wrdata !== v.exp_wd))
        stable = 1'b0;
      gstall = v.exp_gnt_d ? bus.dbus_stall : bus.ibus_stall;
      if (!gstall) done_k = k;
    end
    check({tag, "_latency"}, done_k, W + 1);
    check({tag, "_state_done"}, {30'd0, dbg_state}, {30'd0, S_DONE});
    check({tag, "_rd_cycles"}, rd_n, v.exp_write ? 0 : W);
    check({tag, "_wr_cycles"}, wr_n, v.exp_write ? W : 0);
    check({tag, "_bus_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_mem_address"}, {2'b00, bus.mem_address}, {2'b00, v.exp_addr});
    check({tag, "_ibus_rddata"}, bus.ibus_rddata, v.exp_i_rdata);
    check({tag, "_dbus_rddata"}, bus.dbus_rddata, v.exp_d_rdata);
    drive_idle();
    @(negedge clk);
    check({tag, "_back_idle"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
  endtask

  function automatic vec_t mk(input logic i_rd, input logic i_wr, input logic [31:0] i_addr,
                              input logic [3:0] i_be, input logic [31:0] i_wd,
                              input logic d_rd, input logic d_wr, input logic [31:0] d_addr,
                              input logic [3:0] d_be, input logic [31:0] d_wd,
                              input logic [31:0] mem_rdata, input logic exp_gnt_d,
                              input logic [29:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic exp_write,
                              input logic [31:0] exp_i_rdata, input logic [31:0] exp_d_rdata);
    vec_t v;
    v.i_rd = i_rd; v.i_wr = i_wr; v.i_addr = i_addr; v.i_be = i_be; v.i_wd = i_wd;
    v.d_rd = d_rd; v.d_wr = d_wr; v.d_addr = d_addr; v.d_be = d_be; v.d_wd = d_wd;
    v.mem_rdata = mem_rdata; v.exp_gnt_d = exp_gnt_d; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_wd = exp_wd; v.exp_write = exp_write;
    v.exp_i_rdata = exp_i_rdata; v.exp_d_rdata = exp_d_rdata;
    return v;
  endfunction

  initial begin
    int done_k;
    int rd_n;
    logic exp_d;
    logic won_d;
    checks = 0;
    failures = 0;

    // ibus read 0x10
    vecs[0] = mk(1, 0, 32'h0000_0010, 4'hF, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0,
                 32'h3C01_1234, 0, 30'h4, 4'hF, 32'h0, 0, 32'h3C01_1234, 32'h0);
    // dbus write 0x100, be 0011
    vecs[1] = mk(0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF,
                 32'h5555_5555, 1, 30'h40, 4'b0011, 32'hDEAD_BEEF, 1, 32'h3C01_1234, 32'h0);
    // dbus read 0x204
    vecs[2] = mk(0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0000_0204, 4'hF, 32'h1111_0000,
                 32'hCAFE_F00D, 1, 30'h81, 4'hF, 32'h1111_0000, 0, 32'h3C01_1234, 32'hCAFE_F00D);
    // ibus write leaves ibus_rddata alone
    vecs[3] = mk(0, 1, 32'h0000_03FC, 4'b1100, 32'h0BAD_C0DE, 0, 0, 32'h0, 4'h0, 32'h0,
                 32'h2222_3333, 0, 30'hFF, 4'b1100, 32'h0BAD_C0DE, 1, 32'h3C01_1234, 32'hCAFE_F00D);
    // dbus read+write -> write only
    vecs[4] = mk(0, 0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h0000_0008, 4'hF, 32'h1111_2222,
                 32'h9999_9999, 1, 30'h2, 4'hF, 32'h1111_2222, 1, 32'h3C01_1234, 32'hCAFE_F00D);
    // ibus read at top of address space
    vecs[5] = mk(1, 0, 32'hFFFF_FFFF, 4'b0001, 32'h4444_4444, 0, 0, 32'h0, 4'h0, 32'h0,
                 32'hA5A5_A5A5, 0, 30'h3FFF_FFFF, 4'b0001, 32'h4444_4444, 0, 32'hA5A5_A5A5, 32'hCAFE_F00D);

    rst_n = 1'b0;
    drive_idle();
    bus.ibus_address = 32'h0; bus.ibus_byteenable = 4'h0; bus.ibus_wrdata = 32'h0;
    bus.dbus_address = 32'h0; bus.dbus_byteenable = 4'h0; bus.dbus_wrdata = 32'h0;
    bus.mem_rddata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("reset_mem_rd_wr", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    check("reset_mem_address", {2'b00, bus.mem_address}, 32'd0);
    check("reset_mem_wrdata", bus.mem_wrdata, 32'd0);
    check("reset_rddata", bus.ibus_rddata | bus.dbus_rddata, 32'd0);
    check("reset_stall", {30'd0, bus.ibus_stall, bus.dbus_stall}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // contention: both ports read for 4 grants, back-to-back
    bus.ibus_address = 32'h0000_0020; bus.dbus_address = 32'h0000_0030;
    bus.ibus_read = 1'b1; bus.dbus_read = 1'b1; bus.mem_rddata = 32'h0F0F_0F0F;
    for (int t = 0; t < 4; t++) begin
      done_k = 0;
      won_d = 1'b0;
      for (int k = 1; k <= 12 && done_k == 0; k++) begin
        @(negedge clk);
        if (!bus.dbus_stall || !bus.ibus_stall) begin
          done_k = k;
          won_d = ~bus.dbus_stall;
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (t % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("contend%0d_winner", t), {31'd0, won_d}, {31'd0, exp_d});
      check($sformatf("contend%0d_spacing", t), done_k, (t == 0) ? W + 1 : W + 2);
    end
    drive_idle();
    @(negedge clk);

    // dbus read withdrawn after the first ACCESS cycle still completes
    bus.dbus_address = 32'h0000_0040; bus.dbus_read = 1'b1; bus.mem_rddata = 32'h600D_F00D;
    rd_n = 0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      rd_n += int'(bus.mem_rd);
      if (k == W + 1) check("withdraw_state_done", {30'd0, dbg_state}, {30'd0, S_DONE});
      drive_idle();
    end
    check("withdraw_rd_cycles", rd_n, W);
    check("withdraw_dbus_rddata", bus.dbus_rddata, 32'h600D_F00D);
    @(negedge clk);
    check("withdraw_back_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // reset in the second ACCESS cycle of a dbus read
    bus.dbus_address = 32'h0000_0080; bus.dbus_read = 1'b1; bus.mem_rddata = 32'h7777_7777;
    repeat (2) @(negedge clk);
    check("abort_pre_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("abort_dbus_rddata", bus.dbus_rddata, 32'd0);
    check("abort_mem_address", {2'b00, bus.mem_address}, 32'd0);
    @(negedge clk);
    check("abort_hold_rddata", bus.dbus_rddata, 32'd0);
    rst_n = 1'b1;
    bus.mem_rddata = 32'h1357_9BDF;
    done_k = 0;
    for (int k = 1; k <= 12 && done_k == 0; k++) begin
      @(negedge clk);
      if (!bus.dbus_stall) done_k = k;
    end
    check("reissue_latency", done_k, W + 1);
    check("reissue_mem_address", {2'b00, bus.mem_address}, 32'h20);
    check("reissue_dbus_rddata", bus.dbus_rddata, 32'h1357_9BDF);
    check("reissue_ibus_rddata", bus.ibus_rddata, 32'd0);
    drive_idle();
    @(negedge clk);
    check("reissue_back_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
